// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the pipeline datapath and its stall/flush sequencer.
// The sequencer uses the slave view; whatever drives it uses the master view.
interface pipeline_sequencer_if;
    localparam int unsigned REG_W = 5;
    localparam int unsigned SRC_W = 2;
    localparam int unsigned CNT_W = 16;

    logic             ihit;
    logic             dhit;
    logic             dREN_MEM;
    logic             dWEN_MEM;
    logic             halt_MEM;
    logic [SRC_W-1:0] PC_Src_MEM;
    logic             memtoReg_EX;
    logic [REG_W-1:0] rt_EX;
    logic [REG_W-1:0] rs_ID;
    logic [REG_W-1:0] rt_ID;

    logic             dREN;
    logic             dWEN;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  ihit, dhit, dREN_MEM, dWEN_MEM, halt_MEM, PC_Src_MEM,
               memtoReg_EX, rt_EX, rs_ID, rt_ID,
        output dREN, dWEN, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halt, stall_cnt
    );

    modport master (
        output ihit, dhit, dREN_MEM, dWEN_MEM, halt_MEM, PC_Src_MEM,
               memtoReg_EX, rt_EX, rs_ID, rt_ID,
        input  dREN, dWEN, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halt, stall_cnt
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Five-stage pipeline sequencer: latch enables, bubble flushes, data-request gating,
// sticky halt and a saturating stall-cycle counter.
module pipeline_sequencer (
    input logic                   CLK,
    input logic                   RST,
    pipeline_sequencer_if.slave   bus
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DDONE  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             halt_q, halt_d;

    logic dreq;
    logic mem_ok;
    logic adv;
    logic lu;
    logic taken;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            halt_q      <= halt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;

        dreq   = bus.dREN_MEM | bus.dWEN_MEM;
        // DDONE remembers that the data access already completed while IF was stalled.
        mem_ok = !dreq | bus.dhit | (state_q == DDONE);
        adv    = bus.ihit & mem_ok & (state_q != HALTED);
        lu     = bus.memtoReg_EX & (bus.rt_EX != 5'd0) &
                 ((bus.rt_EX == bus.rs_ID) | (bus.rt_EX == bus.rt_ID));
        taken  = adv & (bus.PC_Src_MEM != 2'b00);

        bus.idex_en     = adv;
        bus.exmem_en    = adv;
        bus.memwb_en    = adv;
        // A taken branch squashes the dependent instruction anyway, so it wins over load-use.
        bus.pc_en       = taken | (adv & !lu);
        bus.ifid_en     = taken | (adv & !lu);
        bus.ifid_flush  = taken;
        bus.idex_flush  = taken | (adv & lu);
        bus.exmem_flush = taken;

        bus.dREN = (state_q == RUN) & bus.dREN_MEM;
        bus.dWEN = (state_q == RUN) & bus.dWEN_MEM;

        case (state_q)
            RUN: begin
                if (adv & bus.halt_MEM)
                    state_d = HALTED;
                else if (dreq & bus.dhit & !bus.ihit)
                    state_d = DDONE;
            end
            DDONE: begin
                if (adv & bus.halt_MEM)
                    state_d = HALTED;
                else if (bus.ihit)
                    state_d = RUN;
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase

        if ((state_q != HALTED) && !adv && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        halt_d = (state_d == HALTED);
    end

    assign bus.halt      = halt_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed scenario bench for pipeline_sequencer with hand-computed expectations.
module tb_pipeline_sequencer;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    pipeline_sequencer_if bus ();

    pipeline_sequencer dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    logic [4:0] en;
    logic [2:0] fl;
    assign en = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en};
    assign fl = {bus.ifid_flush, bus.idex_flush, bus.exmem_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.ihit        = 1'b1;
        bus.dhit        = 1'b0;
        bus.dREN_MEM    = 1'b0;
        bus.dWEN_MEM    = 1'b0;
        bus.halt_MEM    = 1'b0;
        bus.PC_Src_MEM  = 2'b00;
        bus.memtoReg_EX = 1'b0;
        bus.rt_EX       = 5'd0;
        bus.rs_ID       = 5'd0;
        bus.rt_ID       = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.dREN_MEM = 1'b1;
        bus.dhit     = 1'b1;
        #2;
        total_cnt++; if (bus.halt !== 1'b0) $display("FAIL rst_halt: got %b exp 0", bus.halt); else pass_cnt++;
        total_cnt++; if (bus.stall_cnt !== 16'd0) $display("FAIL rst_stall: got %0d exp 0", bus.stall_cnt); else pass_cnt++;
        total_cnt++; if (en !== 5'b11111) $display("FAIL rst_en: got %b exp 11111", en); else pass_cnt++;
        total_cnt++; if (bus.dREN !== 1'b1) $display("FAIL rst_dren: got %b exp 1", bus.dREN); else pass_cnt++;
        step();
        step();
        total_cnt++; if (bus.stall_cnt !== 16'd0) $display("FAIL rst_hold_stall: got %0d exp 0", bus.stall_cnt); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_normal();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++; if (en !== 5'b11111) $display("FAIL norm_en[%0d]: got %b exp 11111", i, en); else pass_cnt++;
            total_cnt++; if (fl !== 3'b000) $display("FAIL norm_fl[%0d]: got %b exp 000", i, fl); else pass_cnt++;
            step();
        end
        total_cnt++; if (bus.stall_cnt !== 16'd0) $display("FAIL norm_stall: got %0d exp 0", bus.stall_cnt); else pass_cnt++;
    endtask

    task automatic test_dmem_stall();
        do_reset();
        bus.dREN_MEM = 1'b1;
        bus.dhit     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if (en !== 5'b00000) $display("FAIL dst_en[%0d]: got %b exp 00000", i, en); else pass_cnt++;
            total_cnt++; if (bus.stall_cnt !== 16'(i)) $display("FAIL dst_cnt[%0d]: got %0d exp %0d", i, bus.stall_cnt, i); else pass_cnt++;
            total_cnt++; if (bus.dREN !== 1'b1) $display("FAIL dst_dren[%0d]: got %b exp 1", i, bus.dREN); else pass_cnt++;
            step();
        end
        bus.dhit = 1'b1;
        #1;
        total_cnt++; if (en !== 5'b11111) $display("FAIL dst_hit_en: got %b exp 11111", en); else pass_cnt++;
        total_cnt++; if (bus.stall_cnt !== 16'd3) $display("FAIL dst_cnt3: got %0d exp 3", bus.stall_cnt); else pass_cnt++;
        step();
        bus.dREN_MEM = 1'b0;
        bus.dhit     = 1'b0;
        bus.dWEN_MEM = 1'b1;
        #1;
        total_cnt++; if (bus.stall_cnt !== 16'd3) $display("FAIL dst_cnt_hold: got %0d exp 3", bus.stall_cnt); else pass_cnt++;
        total_cnt++; if ({bus.dREN, bus.dWEN} !== 2'b01) $display("FAIL dst_dwen: got %b exp 01", {bus.dREN, bus.dWEN}); else pass_cnt++;
        total_cnt++; if (en !== 5'b00000) $display("FAIL dst_wr_en: got %b exp 00000", en); else pass_cnt++;
    endtask

    task automatic test_ddone();
        do_reset();
        bus.dREN_MEM = 1'b1;
        bus.dhit     = 1'b1;
        bus.ihit     = 1'b0;
        #1;
        total_cnt++; if (bus.dREN !== 1'b1) $display("FAIL dd_dren0: got %b exp 1", bus.dREN); else pass_cnt++;
        total_cnt++; if (en !== 5'b00000) $display("FAIL dd_en0: got %b exp 00000", en); else pass_cnt++;
        step();
        bus.dhit = 1'b0;
        #1;
        total_cnt++; if (bus.dREN !== 1'b0) $display("FAIL dd_dren1: got %b exp 0", bus.dREN); else pass_cnt++;
        total_cnt++; if (en !== 5'b00000) $display("FAIL dd_en1: got %b exp 00000", en); else pass_cnt++;
        step();
        bus.ihit = 1'b1;
        #1;
        total_cnt++; if (bus.dREN !== 1'b0) $display("FAIL dd_dren2: got %b exp 0", bus.dREN); else pass_cnt++;
        total_cnt++; if (en !== 5'b11111) $display("FAIL dd_adv: got %b exp 11111", en); else pass_cnt++;
        total_cnt++; if (bus.stall_cnt !== 16'd2) $display("FAIL dd_cnt: got %0d exp 2", bus.stall_cnt); else pass_cnt++;
        step();
        #1;
        total_cnt++; if (bus.dREN !== 1'b1) $display("FAIL dd_back_run_dren: got %b exp 1", bus.dREN); else pass_cnt++;
        total_cnt++; if (en !== 5'b00000) $display("FAIL dd_back_run_en: got %b exp 00000", en); else pass_cnt++;
        // Re-enter DDONE, then hit it with an asynchronous reset mid-cycle.
        bus.dhit = 1'b1;
        bus.ihit = 1'b0;
        step();
        bus.dhit = 1'b0;
        #1;
        total_cnt++; if (bus.dREN !== 1'b0) $display("FAIL dd_re_enter: got %b exp 0", bus.dREN); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (bus.dREN !== 1'b1) $display("FAIL dd_rst_run: got %b exp 1", bus.dREN); else pass_cnt++;
        total_cnt++; if (bus.stall_cnt !== 16'd0) $display("FAIL dd_rst_cnt: got %0d exp 0", bus.stall_cnt); else pass_cnt++;
        step();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        bus.memtoReg_EX = 1'b1;
        bus.rt_EX = 5'd5; bus.rs_ID = 5'd5; bus.rt_ID = 5'd0;
        #1;
        total_cnt++; if (en !== 5'b00111) $display("FAIL lu_rs_en: got %b exp 00111", en); else pass_cnt++;
        total_cnt++; if (fl !== 3'b010) $display("FAIL lu_rs_fl: got %b exp 010", fl); else pass_cnt++;
        bus.rs_ID = 5'd3; bus.rt_ID = 5'd5;
        #1;
        total_cnt++; if (en !== 5'b00111) $display("FAIL lu_rt_en: got %b exp 00111", en); else pass_cnt++;
        total_cnt++; if (fl !== 3'b010) $display("FAIL lu_rt_fl: got %b exp 010", fl); else pass_cnt++;
        bus.rt_EX = 5'd0; bus.rs_ID = 5'd0; bus.rt_ID = 5'd0;
        #1;
        total_cnt++; if (en !== 5'b11111) $display("FAIL lu_r0_en: got %b exp 11111", en); else pass_cnt++;
        total_cnt++; if (fl !== 3'b000) $display("FAIL lu_r0_fl: got %b exp 000", fl); else pass_cnt++;
        bus.rt_EX = 5'd5; bus.rs_ID = 5'd6; bus.rt_ID = 5'd7;
        #1;
        total_cnt++; if (en !== 5'b11111) $display("FAIL lu_nomatch_en: got %b exp 11111", en); else pass_cnt++;
        bus.rs_ID = 5'd5; bus.memtoReg_EX = 1'b0;
        #1;
        total_cnt++; if (en !== 5'b11111) $display("FAIL lu_noload_en: got %b exp 11111", en); else pass_cnt++;
        bus.memtoReg_EX = 1'b1; bus.ihit = 1'b0;
        #1;
        total_cnt++; if (fl !== 3'b000) $display("FAIL lu_noadv_fl: got %b exp 000", fl); else pass_cnt++;
        total_cnt++; if (en !== 5'b00000) $display("FAIL lu_noadv_en: got %b exp 00000", en); else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        bus.memtoReg_EX = 1'b1;
        bus.rt_EX = 5'd9; bus.rs_ID = 5'd9;
        bus.PC_Src_MEM = 2'b01;
        #1;
        total_cnt++; if (en !== 5'b11111) $display("FAIL br_lu_en: got %b exp 11111", en); else pass_cnt++;
        total_cnt++; if (fl !== 3'b111) $display("FAIL br_lu_fl: got %b exp 111", fl); else pass_cnt++;
        bus.memtoReg_EX = 1'b0; bus.PC_Src_MEM = 2'b10;
        #1;
        total_cnt++; if (fl !== 3'b111) $display("FAIL br_jmp_fl: got %b exp 111", fl); else pass_cnt++;
        bus.dWEN_MEM = 1'b1; bus.dhit = 1'b0;
        #1;
        total_cnt++; if (fl !== 3'b000) $display("FAIL br_stall_fl: got %b exp 000", fl); else pass_cnt++;
        total_cnt++; if (en !== 5'b00000) $display("FAIL br_stall_en: got %b exp 00000", en); else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_halt();
        do_reset();
        bus.dREN_MEM = 1'b1;
        step();
        step();
        bus.dREN_MEM = 1'b0;
        bus.halt_MEM = 1'b1;
        #1;
        total_cnt++; if (en !== 5'b11111) $display("FAIL hlt_last_en: got %b exp 11111", en); else pass_cnt++;
        total_cnt++; if (bus.halt !== 1'b0) $display("FAIL hlt_early: got %b exp 0", bus.halt); else pass_cnt++;
        step();
        bus.halt_MEM = 1'b0;
        bus.dREN_MEM = 1'b1; bus.dhit = 1'b1;
        bus.memtoReg_EX = 1'b1; bus.rt_EX = 5'd4; bus.rs_ID = 5'd4;
        bus.PC_Src_MEM = 2'b11;
        for (int i = 0; i < 10; i++) begin
            #1;
            total_cnt++; if (bus.halt !== 1'b1) $display("FAIL hlt_halt[%0d]: got %b exp 1", i, bus.halt); else pass_cnt++;
            total_cnt++; if ({en, fl, bus.dREN} !== 9'd0) $display("FAIL hlt_out[%0d]: got %b exp 0", i, {en, fl, bus.dREN}); else pass_cnt++;
            step();
        end
        total_cnt++; if (bus.stall_cnt !== 16'd2) $display("FAIL hlt_cnt: got %0d exp 2", bus.stall_cnt); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (bus.halt !== 1'b0) $display("FAIL hlt_rst_halt: got %b exp 0", bus.halt); else pass_cnt++;
        total_cnt++; if (bus.stall_cnt !== 16'd0) $display("FAIL hlt_rst_cnt: got %0d exp 0", bus.stall_cnt); else pass_cnt++;
        step();
        rst = 1'b0;
        idle_inputs();
        // Halt resolved while sitting in DDONE.
        bus.dREN_MEM = 1'b1; bus.dhit = 1'b1; bus.ihit = 1'b0;
        step();
        bus.dhit = 1'b0; bus.ihit = 1'b1; bus.halt_MEM = 1'b1;
        #1;
        total_cnt++; if (en !== 5'b11111) $display("FAIL hlt_dd_en: got %b exp 11111", en); else pass_cnt++;
        step();
        total_cnt++; if (bus.halt !== 1'b1) $display("FAIL hlt_dd_halt: got %b exp 1", bus.halt); else pass_cnt++;
        do_reset();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        idle_inputs();
        test_reset();
        test_normal();
        test_dmem_stall();
        test_ddone();
        test_load_use();
        test_branch();
        test_halt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port ihit, input, 1: instruction fetch completes this cycle.
REQ-004 SHALL have port dhit, input, 1: data access completes this cycle.
REQ-005 SHALL have ports dREN_MEM and dWEN_MEM, input, 1 each: MEM-stage read and write requests.
REQ-006 SHALL have ports halt_MEM, input, 1, and PC_Src_MEM, input, 2: halt instruction in MEM; nonzero means a taken branch or jump resolved in MEM.
REQ-007 SHALL have ports memtoReg_EX, input, 1; rt_EX, rs_ID and rt_ID, input, 5 each: load-use detection.
REQ-008 SHALL have ports dREN and dWEN, output, 1 each: gated data requests to the memory controller.
REQ-009 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en and memwb_en, 1 each: latch enables.
REQ-010 SHALL have outputs ifid_flush, idex_flush and exmem_flush, 1 each: bubble insert on the next edge.
REQ-011 SHALL have output halt, 1: sticky processor halt.
REQ-012 SHALL have output stall_cnt, 16: saturating stall-cycle counter.

Function
REQ-013 SHALL implement FSM states RUN, DDONE and HALTED.
REQ-014 SHALL compute dreq = dREN_MEM | dWEN_MEM.
REQ-015 SHALL compute mem_ok = !dreq | dhit | (state==DDONE).
REQ-016 SHALL compute adv = ihit & mem_ok & (state!=HALTED).
REQ-017 SHALL drive idex_en = exmem_en = memwb_en = adv, combinationally.
REQ-018 SHALL compute lu = memtoReg_EX & (rt_EX!=0) & ((rt_EX==rs_ID) | (rt_EX==rt_ID)).
REQ-019 SHALL drive pc_en = ifid_en = adv & !lu, except as overridden by REQ-020.
REQ-020 SHALL, on a taken branch (adv & PC_Src_MEM!=0): assert ifid_flush, idex_flush and exmem_flush; force pc_en = ifid_en = 1; branch overrides lu.
REQ-021 SHALL, on load-use (adv & lu & PC_Src_MEM==0): assert idex_flush only; hold PC and IF/ID.
REQ-022 SHALL deassert all flushes whenever adv = 0.
REQ-023 SHALL pass dREN = dREN_MEM and dWEN = dWEN_MEM in RUN; force both to 0 in DDONE and HALTED.
REQ-024 SHALL transition RUN -> DDONE when dreq & dhit & !ihit.
REQ-025 SHALL transition DDONE -> RUN when ihit; adv = 1 in that cycle.
REQ-026 SHALL transition RUN or DDONE -> HALTED when adv & halt_MEM, with memwb_en = 1 in that cycle; halt takes priority over the RUN -> DDONE transition.
REQ-027 SHALL remain in HALTED until RST; all enables and flushes are 0 in HALTED.
REQ-028 SHALL drive halt = (state==HALTED), registered.
REQ-029 SHALL increment stall_cnt by 1 on each edge where state!=HALTED and adv = 0; it saturates at 16'hFFFF with no wrap-around.
REQ-030 SHALL have all outputs depend only on current inputs and state, with no added latency.

Reset
REQ-031 SHALL, while RST = 1: hold state = RUN, halt = 0, stall_cnt = 0; combinational outputs follow REQ-013 to REQ-030 for the RUN state.
REQ-032 SHALL, on RST asserted mid-DDONE or mid-HALTED, return to RUN immediately; no stall count is retained.

Verification
REQ-033 SHALL cover: ihit = 1, no dreq -> all enables = 1, flushes = 0, stall_cnt holds at 0.
REQ-034 SHALL cover: dREN_MEM = 1, dhit = 0 for 3 cycles, then dhit = 1 with ihit = 1 -> enables = 0 for 3 cycles, stall_cnt = 3, then all enables = 1.
REQ-035 SHALL cover: dREN_MEM = 1, dhit = 1 with ihit = 0, then ihit = 1 two cycles later -> DDONE entered, dREN = 0 while in DDONE, adv = 1 on the ihit cycle, state returns to RUN.
REQ-036 SHALL cover: memtoReg_EX = 1, rt_EX = 5, rs_ID = 5, ihit = 1 -> pc_en = 0, ifid_en = 0, idex_flush = 1; repeating with rt_EX = 0 -> no stall.
REQ-037 SHALL cover: PC_Src_MEM = 2'b01 together with the lu condition, ihit = 1 -> three flushes = 1, pc_en = 1.
REQ-038 SHALL cover: halt_MEM = 1 with adv -> memwb_en = 1 in that cycle, then halt = 1 and all enables = 0 for 10 cycles; RST pulse -> halt = 0, stall_cnt = 0.
